// File: rtl/rr_mux_arb_pkg.sv
// Shared definitions for the N-channel arbitrated registered multiplexer.
package rr_mux_arb_pkg;

    localparam logic [1:0] MODE_RR    = 2'b00;
    localparam logic [1:0] MODE_FIXED = 2'b01;
    localparam logic [1:0] MODE_FORCE = 2'b10;

    // Channel-index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_mux_arb_arbiter.sv
// Combinational channel arbiter: round-robin, fixed priority or forced select.
module rr_arbiter
    import rr_mux_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CW   = ch_width(N_CH)
) (
    input  logic [1:0]      mode,
    input  logic [CW-1:0]   ptr,
    input  logic [CW-1:0]   sel,
    input  logic [N_CH-1:0] valid,
    output logic [N_CH-1:0] grant,
    output logic [CW-1:0]   idx,
    output logic            found
);

    localparam int unsigned N_U = N_CH;

    int unsigned ptr_u;
    int unsigned k;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        grant = '0;
        ptr_u = 32'(ptr);
        k     = 0;
        case (mode)
            MODE_FIXED: begin
                for (int unsigned i = 0; i < N_U; i++) begin
                    if (!found && valid[i]) begin
                        found = 1'b1;
                        idx   = CW'(i);
                    end
                end
            end
            MODE_FORCE: begin
                // sel values at or beyond N_CH match no loop index, so never grant
                for (int unsigned i = 0; i < N_U; i++) begin
                    if (32'(sel) == i && valid[i]) begin
                        found = 1'b1;
                        idx   = CW'(i);
                    end
                end
            end
            default: begin
                for (int unsigned i = 0; i < N_U; i++) begin
                    k = (ptr_u + i) % N_U;
                    if (!found && valid[k]) begin
                        found = 1'b1;
                        idx   = CW'(k);
                    end
                end
            end
        endcase
        for (int unsigned i = 0; i < N_U; i++) begin
            grant[i] = found && (32'(idx) == i);
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel, W-bit registered multiplexer with valid/ready handshakes and a built-in arbiter.
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter  int N_CH = 4,
    parameter  int W    = 8,
    localparam int CW   = ch_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [CW-1:0]     sel,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [CW-1:0]     out_ch,
    input  logic              out_ready
);

    localparam int unsigned N_U = N_CH;

    logic [CW-1:0]   ptr;
    logic [N_CH-1:0] grant;
    logic [CW-1:0]   grant_idx;
    logic            grant_any;
    logic            load_en;
    logic            xfer;
    logic            rr_mode;
    logic [W-1:0]    mux_data;
    logic [CW-1:0]   ptr_next;

    rr_arbiter #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_arb (
        .mode  (mode),
        .ptr   (ptr),
        .sel   (sel),
        .valid (in_valid),
        .grant (grant),
        .idx   (grant_idx),
        .found (grant_any)
    );

    assign load_en  = !out_valid || out_ready;
    assign in_ready = (load_en && !rst) ? grant : '0;
    assign xfer     = |in_ready;
    assign rr_mode  = (mode != MODE_FIXED) && (mode != MODE_FORCE);
    assign ptr_next = (32'(grant_idx) == N_U - 1) ? '0 : grant_idx + 1'b1;

    always_comb begin
        mux_data = '0;
        for (int unsigned i = 0; i < N_U; i++) begin
            if (grant[i]) begin
                mux_data = in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            // A drained register with no new grant empties but keeps its last word
            out_valid <= xfer;
            if (xfer) begin
                out_data <= mux_data;
                out_ch   <= grant_idx;
                if (rr_mode) begin
                    ptr <= ptr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed self-checking bench for rr_mux_arb (N_CH=4, W=8).
module tb_rr_mux_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    int n_checks;
    int n_fail;

    logic [7:0] dvals [4];

    rr_mux_arb #(
        .N_CH (4),
        .W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mode      = 2'b00;
        sel       = 2'd0;
        in_valid  = 4'b0000;
        in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        mode      = 2'b00;
        in_valid  = 4'b1111;
        in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
        out_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        n_checks++;
        if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
        n_checks++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
            n_fail++;
            $display("FAIL reset_first_word: got v=%b ch=%0d d=%h expected v=1 ch=0 d=10", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch [5];
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_ch !== exp_ch[i] || out_data !== dvals[exp_ch[i]]) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                         i, out_valid, out_ch, out_data, exp_ch[i], dvals[exp_ch[i]]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        in_valid = 4'b0010;
        step();                         // ch1 in round-robin moves ptr to 2
        mode     = 2'b01;
        in_valid = 4'b0110;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL fixed_in_ready: got %b expected 0010", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_ch !== 2'd1 || out_data !== 8'h21) begin
                n_fail++;
                $display("FAIL fixed_grant[%0d]: got ch=%0d d=%h expected ch=1 d=21", i, out_ch, out_data);
            end
        end
        mode = 2'b00;
        step();
        n_checks++;
        if (out_ch !== 2'd2 || out_data !== 8'h32) begin
            n_fail++;
            $display("FAIL fixed_to_rr: got ch=%0d d=%h expected ch=2 d=32", out_ch, out_data);
        end
        step();
        n_checks++;
        if (out_ch !== 2'd1 || out_data !== 8'h21) begin
            n_fail++;
            $display("FAIL rr_wrap_after_fixed: got ch=%0d d=%h expected ch=1 d=21", out_ch, out_data);
        end
    endtask

    task automatic test_forced_select();
        do_reset();
        in_valid = 4'b0111;
        step();                         // ch0 loaded, ptr=1
        mode = 2'b10;
        sel  = 2'd3;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL force_no_grant: got %b expected 0000", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 8'h10) begin
            n_fail++;
            $display("FAIL force_drop: got v=%b ch=%0d d=%h expected v=0 ch=0 d=10", out_valid, out_ch, out_data);
        end
        in_valid       = 4'b1111;
        in_data[31:24] = 8'hA5;
        #1;
        n_checks++;
        if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL force_in_ready: got %b expected 1000", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL force_load: got v=%b ch=%0d d=%h expected v=1 ch=3 d=a5", out_valid, out_ch, out_data);
        end
        // mode 11 behaves as round-robin; ptr is still 1 since forced grants leave it alone
        mode = 2'b11;
        step();
        n_checks++;
        if (out_ch !== 2'd1 || out_data !== 8'h21) begin
            n_fail++;
            $display("FAIL mode11_rr: got ch=%0d d=%h expected ch=1 d=21", out_ch, out_data);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 4'b1111;
        step();                         // ch0 loaded, ptr=1
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_in_ready[%0d]: got %b expected 0000", i, in_ready);
            end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=0 d=10", i, out_valid, out_ch, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h21) begin
            n_fail++;
            $display("FAIL bp_reload: got v=%b ch=%0d d=%h expected v=1 ch=1 d=21", out_valid, out_ch, out_data);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'h32) begin
            n_fail++;
            $display("FAIL bp_no_bubble: got v=%b ch=%0d d=%h expected v=1 ch=2 d=32", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        in_valid = 4'b1111;
        step();
        step();                         // ch1 held, ptr=2
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 0000", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_clear: got v=%b ch=%0d d=%h expected v=0 ch=0 d=00", out_valid, out_ch, out_data);
        end
        rst      = 1'b0;
        in_valid = 4'b1110;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL midrst_ptr: got %b expected 0010", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h21) begin
            n_fail++;
            $display("FAIL midrst_grant: got v=%b ch=%0d d=%h expected v=1 ch=1 d=21", out_valid, out_ch, out_data);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        dvals     = '{8'h10, 8'h21, 8'h32, 8'h43};
        rst       = 1'b1;
        mode      = 2'b00;
        sel       = 2'd0;
        in_valid  = 4'b0000;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_forced_select();
        test_backpressure();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised successor to the team's 4:1 select mux: an N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- The channel is chosen by a built-in arbiter with three modes: round-robin, fixed priority, or forced select (the classic mux behaviour).
- Sits between multiple producers and a single shared consumer; one output register stage.

Parameters:
N_CH, 4, number of input channels (>=2)
W, 8, data width per channel
CW, max(1,$clog2(N_CH)), channel index width (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
mode  input  2  00 round-robin, 01 fixed priority (lowest index wins), 10 forced select, 11 treated as 00
sel  input  CW  channel index used in forced-select mode
in_valid  input  N_CH  per-channel data valid
in_data  input  N_CH*W  channel k occupies bits [k*W +: W]
in_ready  output  N_CH  per-channel accept, combinational
out_valid  output  1  output register holds a word
out_data  output  W  registered data
out_ch  output  CW  index of the source channel of out_data
out_ready  input  1  consumer accept

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0.
  - in_ready is all-zero while rst=1.
- load_en = !out_valid || out_ready (combinational).
- Grant (combinational, one-hot or none, only when load_en=1):
  - Round-robin: the first k with in_valid[k]=1, scanning ptr, ptr+1, ..., wrapping mod N_CH.
  - Fixed priority: the lowest k with in_valid[k]=1.
  - Forced select: k=sel if sel<N_CH and in_valid[sel]=1; otherwise no grant. sel>=N_CH never grants.
- in_ready[k] = load_en && grant[k]. A transfer on channel k occurs when in_valid[k] && in_ready[k].
- On a transfer, at the next edge: out_valid=1, out_data=in_data[k], out_ch=k. Latency is 1 cycle from input transfer to out_valid.
- If load_en=1 and there is no grant: out_valid goes to 0 at the next edge; out_data and out_ch hold their previous values.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_ch are stable and all in_ready=0.
- Simultaneous output drain and input accept (out_valid && out_ready plus a new grant): the register reloads in the same cycle. Full throughput is 1 word/cycle.
- ptr update:
  - Only on a transfer while in round-robin mode: ptr <= (k+1) mod N_CH, wrapping from N_CH-1 to 0.
  - Fixed-priority and forced modes leave ptr unchanged.
- mode and sel are sampled combinationally every cycle. A change takes effect on the next arbitration and never corrupts a held output word.
- in_valid may drop without a transfer; the arbiter re-evaluates each cycle with no lock.
- Reset mid-operation: any held word is discarded (out_valid=0 next edge) and ptr returns to 0. No transfer occurs in a cycle where rst=1.

Decomposition:
- Shared package:
  - mode encoding constants MODE_RR=2'b00, MODE_FIXED=2'b01, MODE_FORCE=2'b10.
  - Channel-index width function.
- One natural sub-module, rr_arbiter: mode, ptr, sel and in_valid in; one-hot grant and encoded index out; purely combinational.
- ptr register, output register and handshake logic stay in rr_mux_arb.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0000; after release, first grant is ch0 (ptr=0).
- Round-robin fairness: mode=00, N_CH=4, in_valid=1111, in_data=8'h10,8'h21,8'h32,8'h43, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles with matching data; ptr wraps 3->0.
- Fixed priority: mode=01, in_valid=0110 -> ch1 granted every cycle and ch2 starved. Then switch to mode=00 with ptr=2 -> ch2 is granted next.
- Forced select: mode=10, sel=3, in_valid=0111 -> no grant and out_valid drops to 0. Set in_valid[3]=1, in_data[3]=8'hA5 -> out_data=8'hA5, out_ch=3 one cycle later.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch stable and in_ready=0000. With out_ready=1 and in_valid present, the register reloads in the same cycle with no bubble.
- Mid-operation reset: assert rst while out_valid=1 and ptr=2 -> next cycle out_valid=0 and ptr=0, so the next round-robin grant goes to the lowest valid channel from index 0.
